tipo_pattern_gen: RTL and testbench



---
 rtl/tipo_pattern_gen_if.sv | 24 ++
 rtl/tipo_pattern_gen.sv | 121 ++++++++++++
 tb/tb_tipo_pattern_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/tipo_pattern_gen_if.sv
// Mode/pattern bundle between the PIO mode source and the LED pattern generator.
// The source drives tipo; the generator returns leds, mode and the debug tick.
interface tipo_pattern_gen_if #(
    parameter int LED_W = 8
) ();
    logic [1:0]       tipo;
    logic [LED_W-1:0] leds;
    logic [1:0]       mode;
    logic             tick;

    modport master (
        output tipo,
        input  leds,
        input  mode,
        input  tick
    );

    modport slave (
        input  tipo,
        output leds,
        output mode,
        output tick
    );
endinterface

// File: rtl/tipo_pattern_gen.sv
// LED pattern generator driven by the 2-bit tipo mode word.
// Any change of mode restarts the prescaler and the selected pattern.
module tipo_pattern_gen #(
    parameter int LED_W    = 8,
    parameter int PRESCALE = 50000,
    parameter int PWM_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    tipo_pattern_gen_if.slave  bus
);
    localparam int PCW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PCW-1:0] LAST = PCW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_BLINK   = 2'b01,
        M_CHASE   = 2'b10,
        M_BREATHE = 2'b11
    } mode_e;

    mode_e               tipo_in;
    mode_e               tipo_q;
    logic [PCW-1:0]      pcnt;
    logic [PCW-1:0]      pcnt_d;
    logic                phase;
    logic                phase_d;
    logic [LED_W-1:0]    pos;
    logic [LED_W-1:0]    pos_d;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_d;
    logic                dir_up;
    logic                dir_up_d;
    logic [PWM_BITS-1:0] pwm;
    logic [LED_W-1:0]    leds_q;
    logic [LED_W-1:0]    leds_d;
    logic                chg;
    logic                tick_i;

    assign tipo_in = mode_e'(bus.tipo);

    always_ff @(posedge clk) begin
        if (reset) begin
            tipo_q <= M_OFF;
            pcnt   <= '0;
            phase  <= 1'b1;
            pos    <= LED_W'(1);
            duty   <= '0;
            dir_up <= 1'b1;
            pwm    <= '0;
            leds_q <= '0;
        end else begin
            tipo_q <= tipo_in;
            pcnt   <= pcnt_d;
            phase  <= phase_d;
            pos    <= pos_d;
            duty   <= duty_d;
            dir_up <= dir_up_d;
            pwm    <= pwm + PWM_BITS'(1);
            leds_q <= leds_d;
        end
    end

    always_comb begin
        chg      = (tipo_in != tipo_q);
        tick_i   = (pcnt == LAST);
        pcnt_d   = pcnt + PCW'(1);
        phase_d  = phase;
        pos_d    = pos;
        duty_d   = duty;
        dir_up_d = dir_up;
        leds_d   = '0;

        if (chg || tick_i) begin
            pcnt_d = '0;
        end

        // A mode change reloads every pattern and swallows a coincident tick.
        if (chg) begin
            phase_d  = 1'b1;
            pos_d    = LED_W'(1);
            duty_d   = '0;
            dir_up_d = 1'b1;
        end else if (tick_i) begin
            unique case (tipo_q)
                M_OFF: begin
                end
                M_BLINK: begin
                    phase_d = ~phase;
                end
                M_CHASE: begin
                    pos_d = {pos[LED_W-2:0], pos[LED_W-1]};
                end
                M_BREATHE: begin
                    if (dir_up) begin
                        duty_d = duty + PWM_BITS'(1);
                        if (duty_d == '1) begin
                            dir_up_d = 1'b0;
                        end
                    end else begin
                        duty_d = duty - PWM_BITS'(1);
                        if (duty_d == '0) begin
                            dir_up_d = 1'b1;
                        end
                    end
                end
            endcase
        end

        unique case (tipo_q)
            M_OFF:     leds_d = '0;
            M_BLINK:   leds_d = {LED_W{phase}};
            M_CHASE:   leds_d = pos;
            M_BREATHE: leds_d = {LED_W{pwm < duty}};
        endcase
    end

    assign bus.leds = leds_q;
    assign bus.mode = tipo_q;
    assign bus.tick = tick_i;
endmodule

// File: tb/tb_tipo_pattern_gen.sv
// Directed bench for tipo_pattern_gen with PRESCALE=4, LED_W=8, PWM_BITS=4.
// Expected LED/tick values are derived from edge counts since reset.
module tb_tipo_pattern_gen;
    localparam int LED_W    = 8;
    localparam int PRESCALE = 4;
    localparam int PWM_BITS = 4;

    logic clk = 1'b0;
    logic reset;
    int n_cmp = 0;
    int n_bad = 0;
    int unsigned ecnt = 0;

    always #5 clk = ~clk;

    tipo_pattern_gen_if #(.LED_W(LED_W)) bus ();

    tipo_pattern_gen #(
        .LED_W(LED_W),
        .PRESCALE(PRESCALE),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ecnt = edges since the last reset edge, so pwm after edge k is k mod 16
    task automatic step();
        @(posedge clk);
        if (reset) ecnt = 0;
        else ecnt++;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tri_duty(input int k);
        if (k <= 15) return k;
        if (k <= 30) return 30 - k;
        return k - 30;
    endfunction

    // Called right after the load edge; j counts edges after the load.
    task automatic run_mode(input string tag, input int m, input int n);
        logic [7:0] e;
        logic [7:0] one;
        int idx;
        one = 8'h01;
        for (int j = 1; j <= n; j++) begin
            step();
            idx = (j - 1) / 4;
            case (m)
                1: e = (idx % 2 == 0) ? 8'hFF : 8'h00;
                2: e = one << (idx % 8);
                default: e = 8'h00;
            endcase
            chk($sformatf("%s_leds_j%0d", tag, j), 32'(bus.leds), 32'(e));
            chk($sformatf("%s_tick_j%0d", tag, j), 32'(bus.tick),
                32'((j % 4) == 3));
        end
    endtask

    task automatic run_breathe(input string tag, input int n);
        int duty;
        int pwm_b;
        logic [7:0] e;
        for (int j = 1; j <= n; j++) begin
            step();
            duty  = tri_duty((j - 1) / 4);
            pwm_b = int'((ecnt - 1) % 16);
            e     = (pwm_b < duty) ? 8'hFF : 8'h00;
            chk($sformatf("%s_leds_j%0d", tag, j), 32'(bus.leds), 32'(e));
            chk($sformatf("%s_tick_j%0d", tag, j), 32'(bus.tick),
                32'((j % 4) == 3));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        bus.tipo = 2'b00;
        step();
        step();
        chk("rst_leds", 32'(bus.leds), 32'h00);
        chk("rst_mode", 32'(bus.mode), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        reset = 1'b0;

        // OFF: ticks every 4 clocks, LEDs dark
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("off_tick_k%0d", k), 32'(bus.tick),
                32'((k % 4) == 3));
            chk($sformatf("off_leds_k%0d", k), 32'(bus.leds), 32'h00);
            chk($sformatf("off_mode_k%0d", k), 32'(bus.mode), 32'h0);
        end

        bus.tipo = 2'b01;
        step();
        chk("blink_mode", 32'(bus.mode), 32'h1);
        chk("blink_lat", 32'(bus.leds), 32'h00);
        chk("blink_tick0", 32'(bus.tick), 32'h0);
        run_mode("blink", 1, 12);

        bus.tipo = 2'b10;
        step();
        chk("chase_mode", 32'(bus.mode), 32'h2);
        run_mode("chase", 2, 51);
        chk("chase_pos10", 32'(bus.leds), 32'h10);
        chk("chase_tick_at_sw", 32'(bus.tick), 32'h1);

        // Switch on the tick cycle: the tick must not advance pos
        bus.tipo = 2'b01;
        step();
        chk("sw_mode", 32'(bus.mode), 32'h1);
        chk("sw_no_step", 32'(bus.leds), 32'h10);
        chk("sw_pcnt_clr", 32'(bus.tick), 32'h0);
        run_mode("sw_blink", 1, 6);

        bus.tipo = 2'b11;
        step();
        chk("br_mode", 32'(bus.mode), 32'h3);
        run_breathe("breathe", 128);

        reset = 1'b1;
        step();
        chk("mid_rst_leds", 32'(bus.leds), 32'h00);
        chk("mid_rst_mode", 32'(bus.mode), 32'h0);
        chk("mid_rst_tick", 32'(bus.tick), 32'h0);
        reset = 1'b0;
        step();
        chk("post_rst_mode", 32'(bus.mode), 32'h3);
        chk("post_rst_leds", 32'(bus.leds), 32'h00);
        run_breathe("br_restart", 40);

        // Back-to-back changes: last value wins
        bus.tipo = 2'b01;
        step();
        chk("glitch_mode1", 32'(bus.mode), 32'h1);
        bus.tipo = 2'b10;
        step();
        chk("glitch_mode2", 32'(bus.mode), 32'h2);
        run_mode("glitch", 2, 6);

        bus.tipo = 2'b00;
        step();
        chk("off2_mode", 32'(bus.mode), 32'h0);
        run_mode("off2", 0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
